// File: rtl/cdb_arbiter_pkg.sv
// Shared constants and helpers for the common-data-bus arbiter.
//   ROB_SZ_LOG          : log2 of ROB size; tags are ROB_SZ_LOG+1 bits, tag 0 = "no tag"
//   CDB_N_REQ           : number of result producers
//   CDB_Q_DEPTH         : entries per producer queue (power of two, >= 2)
//   CDB_ALU/LSB/BRU     : producer indices
//   rr_wrap_add()       : (idx + step) mod n for idx, step < n
package cdb_arbiter_pkg;

    localparam int unsigned ROB_SZ_LOG  = 4;
    localparam logic        HIGH        = 1'b1;
    localparam logic        LOW         = 1'b0;

    localparam int unsigned CDB_N_REQ   = 3;
    localparam int unsigned CDB_Q_DEPTH = 2;
    localparam int unsigned CDB_ALU     = 0;
    localparam int unsigned CDB_LSB     = 1;
    localparam int unsigned CDB_BRU     = 2;

    localparam int unsigned CDB_TAG_W   = ROB_SZ_LOG + 1;
    localparam int unsigned CDB_DATA_W  = 32;
    localparam int unsigned CDB_SRC_W   = 2;

    // Both operands are below n, so one conditional subtract is enough.
    function automatic logic [CDB_SRC_W-1:0] rr_wrap_add(input logic [CDB_SRC_W-1:0] idx,
                                                         input int unsigned step,
                                                         input int unsigned n);
        int unsigned sum;
        sum = 32'(idx) + step;
        if (sum >= n) begin
            sum = sum - n;
        end
        return CDB_SRC_W'(sum);
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer request / result broadcast bundle of the CDB arbiter.
//   req_vld/req_tag/req_res : per-producer request, slice i belongs to producer i
//   req_full                : producer i's queue is full
//   cdb_vld/tag/res/src     : registered broadcast bus and winning producer index
// master = producers + bus consumers, slave = arbiter.
interface cdb_arbiter_if
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ  = CDB_N_REQ,
    parameter int unsigned TAG_W  = CDB_TAG_W,
    parameter int unsigned DATA_W = CDB_DATA_W
) ();

    logic [N_REQ-1:0]        req_vld;
    logic [N_REQ*TAG_W-1:0]  req_tag;
    logic [N_REQ*DATA_W-1:0] req_res;
    logic [N_REQ-1:0]        req_full;
    logic                    cdb_vld;
    logic [TAG_W-1:0]        cdb_tag;
    logic [DATA_W-1:0]       cdb_res;
    logic [CDB_SRC_W-1:0]    cdb_src;

    modport master (
        output req_vld, req_tag, req_res,
        input  req_full, cdb_vld, cdb_tag, cdb_res, cdb_src
    );

    modport slave (
        input  req_vld, req_tag, req_res,
        output req_full, cdb_vld, cdb_tag, cdb_res, cdb_src
    );

endinterface

// File: rtl/cdb_arbiter_fifo.sv
// One producer's result queue.
//   clk, rst  : clock, asynchronous active-high reset
//   rdy       : global enable, all state holds when low
//   flush     : synchronous clear (only acts with rdy)
//   push      : write push_data; dropped while full, even if a pop happens too
//   pop       : advance the head; ignored while empty
//   head      : oldest entry (stale when count == 0)
//   count     : occupancy, full : count == DEPTH
module cdb_arbiter_fifo #(
    parameter  int unsigned W     = 37,
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned PW    = $clog2(DEPTH),
    localparam int unsigned CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rdy,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count,
    output logic          full
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && (count_q != '0);
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (rdy) begin
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (do_push) begin
                    mem_q[wr_ptr_q] <= push_data;
                    wr_ptr_q        <= wr_ptr_q + PW'(1);
                end
                if (do_pop) begin
                    rd_ptr_q <= rd_ptr_q + PW'(1);
                end
                count_q <= count_q + CW'(do_push) - CW'(do_pop);
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: queues results from ALU, LSB and BRU and broadcasts one per cycle,
// chosen round-robin, on a registered bus feeding the reservation stations and the ROB.
//   clk, rst : clock, asynchronous active-high reset
//   rdy      : global enable, everything holds when low
//   reset    : synchronous branch-mispredict flush (with rdy), beats everything else
//   bus      : producer requests, req_full backpressure and the cdb_* broadcast
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ   = CDB_N_REQ,
    parameter int unsigned TAG_W   = CDB_TAG_W,
    parameter int unsigned DATA_W  = CDB_DATA_W,
    parameter int unsigned Q_DEPTH = CDB_Q_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rdy,
    input  logic          reset,
    cdb_arbiter_if.slave  bus
);

    localparam int unsigned ENTRY_W = TAG_W + DATA_W;
    localparam int unsigned CNT_W   = $clog2(Q_DEPTH) + 1;

    logic [N_REQ-1:0]     push;
    logic [N_REQ-1:0]     pop;
    logic [N_REQ-1:0]     full;
    logic [N_REQ-1:0]     empty;
    logic [ENTRY_W-1:0]   push_data [N_REQ];
    logic [ENTRY_W-1:0]   head      [N_REQ];
    logic [CNT_W-1:0]     count     [N_REQ];

    logic                 grant_vld;
    logic [CDB_SRC_W-1:0] grant_idx;
    logic [ENTRY_W-1:0]   grant_entry;
    logic [CDB_SRC_W-1:0] cand;

    logic [CDB_SRC_W-1:0] rr_ptr_q;
    logic                 cdb_vld_q;
    logic [TAG_W-1:0]     cdb_tag_q;
    logic [DATA_W-1:0]    cdb_res_q;
    logic [CDB_SRC_W-1:0] cdb_src_q;

    for (genvar i = 0; i < N_REQ; i++) begin : g_queue
        // Tag 0 means "no tag"; such requests never enter the queue.
        assign push[i]      = bus.req_vld[i] && (bus.req_tag[i*TAG_W +: TAG_W] != '0);
        assign push_data[i] = {bus.req_tag[i*TAG_W +: TAG_W], bus.req_res[i*DATA_W +: DATA_W]};
        assign empty[i]     = (count[i] == '0);

        cdb_arbiter_fifo #(
            .W     (ENTRY_W),
            .DEPTH (Q_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .rdy       (rdy),
            .flush     (reset),
            .push      (push[i]),
            .push_data (push_data[i]),
            .pop       (pop[i]),
            .head      (head[i]),
            .count     (count[i]),
            .full      (full[i])
        );
    end

    // First non-empty queue at or after rr_ptr wins.
    always_comb begin
        grant_vld   = LOW;
        grant_idx   = '0;
        grant_entry = '0;
        cand        = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = rr_wrap_add(rr_ptr_q, k, N_REQ);
            if (!grant_vld && !empty[cand]) begin
                grant_vld   = HIGH;
                grant_idx   = cand;
                grant_entry = head[cand];
            end
        end
    end

    // The fifos themselves ignore pops under rdy=0 or flush.
    always_comb begin
        pop = '0;
        if (grant_vld) begin
            pop[grant_idx] = HIGH;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q  <= '0;
            cdb_vld_q <= LOW;
            cdb_tag_q <= '0;
            cdb_res_q <= '0;
            cdb_src_q <= '0;
        end else if (rdy) begin
            if (reset) begin
                rr_ptr_q  <= '0;
                cdb_vld_q <= LOW;
            end else if (grant_vld) begin
                rr_ptr_q  <= rr_wrap_add(grant_idx, 1, N_REQ);
                cdb_vld_q <= HIGH;
                cdb_tag_q <= grant_entry[ENTRY_W-1 -: TAG_W];
                cdb_res_q <= grant_entry[DATA_W-1:0];
                cdb_src_q <= grant_idx;
            end else begin
                // Idle: payload and rr_ptr hold, only valid drops.
                cdb_vld_q <= LOW;
            end
        end
    end

    assign bus.req_full = full;
    assign bus.cdb_vld  = cdb_vld_q;
    assign bus.cdb_tag  = cdb_tag_q;
    assign bus.cdb_res  = cdb_res_q;
    assign bus.cdb_src  = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int unsigned N  = CDB_N_REQ;
    localparam int unsigned TW = CDB_TAG_W;
    localparam int unsigned DW = CDB_DATA_W;

    logic clk;
    logic rst;
    logic rdy;
    logic flush;

    int n_checks;
    int n_fail;

    cdb_arbiter_if bus ();

    cdb_arbiter u_dut (
        .clk   (clk),
        .rst   (rst),
        .rdy   (rdy),
        .reset (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Protocol watch: no tag-0 requests and no pushes into a full queue.
    always @(posedge clk) begin
        if (!rst && rdy && !flush) begin
            for (int i = 0; i < int'(N); i++) begin
                if (bus.req_vld[i]) begin
                    assert (bus.req_tag[i*TW +: TW] != '0)
                        else $error("producer %0d sent tag 0", i);
                    assert (!bus.req_full[i])
                        else $error("producer %0d pushed into a full queue", i);
                end
            end
        end
    end

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] res_of(input logic [TW-1:0] tag);
        return 32'hC0DE_0000 | 32'(tag);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        bus.req_vld = '0;
        bus.req_tag = '0;
        bus.req_res = '0;
    endtask

    task automatic set_req(input int unsigned idx, input logic [TW-1:0] tag,
                           input logic [DW-1:0] res);
        bus.req_vld[idx]           = 1'b1;
        bus.req_tag[idx*TW +: TW]  = tag;
        bus.req_res[idx*DW +: DW]  = res;
    endtask

    // Present the given tags (0 = no request) for one edge.
    task automatic step(input logic [TW-1:0] a, input logic [TW-1:0] l, input logic [TW-1:0] b);
        clear_req();
        if (a != '0) set_req(CDB_ALU, a, res_of(a));
        if (l != '0) set_req(CDB_LSB, l, res_of(l));
        if (b != '0) set_req(CDB_BRU, b, res_of(b));
        tick();
        clear_req();
    endtask

    task automatic expect_cdb(input string name, input logic vld, input logic [TW-1:0] tag,
                              input logic [DW-1:0] res, input logic [1:0] src);
        check_eq({name, "_vld"}, 64'(bus.cdb_vld), 64'(vld));
        if (vld) begin
            check_eq({name, "_tag"}, 64'(bus.cdb_tag), 64'(tag));
            check_eq({name, "_res"}, 64'(bus.cdb_res), 64'(res));
            check_eq({name, "_src"}, 64'(bus.cdb_src), 64'(src));
        end
    endtask

    task automatic expect_bc(input string name, input logic [TW-1:0] tag, input logic [1:0] src);
        expect_cdb(name, 1'b1, tag, res_of(tag), src);
    endtask

    task automatic expect_idle(input string name);
        expect_cdb(name, 1'b0, '0, '0, '0);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        rdy      = 1'b1;
        flush    = 1'b0;
        clear_req();
        tick();
        tick();
        check_eq("rst_vld", 64'(bus.cdb_vld), 64'd0);
        check_eq("rst_tag", 64'(bus.cdb_tag), 64'd0);
        check_eq("rst_res", 64'(bus.cdb_res), 64'd0);
        check_eq("rst_src", 64'(bus.cdb_src), 64'd0);
        check_eq("rst_full", 64'(bus.req_full), 64'd0);
        rst = 1'b0;
        tick();

        // Single request: 2-cycle latency, one-cycle valid.
        set_req(CDB_ALU, 5'd3, 32'h11);
        tick();
        clear_req();
        expect_idle("single_e1");
        tick();
        expect_cdb("single_e2", 1'b1, 5'd3, 32'h11, 2'd0);
        tick();
        expect_idle("single_e3");

        // Contention from rr_ptr=0, then confirm rr_ptr returned to 0.
        do_flush();
        step(5'd4, 5'd5, 5'd6);
        expect_idle("cont_e1");
        step(0, 0, 0);
        expect_bc("cont_e2", 5'd4, 2'd0);
        step(0, 0, 0);
        expect_bc("cont_e3", 5'd5, 2'd1);
        step(0, 0, 0);
        expect_bc("cont_e4", 5'd6, 2'd2);
        step(0, 0, 0);
        expect_idle("cont_e5");
        step(5'd29, 5'd30, 0);
        step(0, 0, 0);
        expect_bc("rr_wrap_a", 5'd29, 2'd0);
        step(0, 0, 0);
        expect_bc("rr_wrap_l", 5'd30, 2'd1);

        // Fairness: ALU streams, LSB tag 9 still gets the second slot.
        do_flush();
        step(5'd10, 5'd9, 0);
        expect_idle("fair_e1");
        check_eq("fair_full_e1", 64'(bus.req_full), 64'b000);
        step(5'd11, 0, 0);
        expect_bc("fair_e2", 5'd10, 2'd0);
        check_eq("fair_full_e2", 64'(bus.req_full), 64'b000);
        step(5'd12, 0, 0);
        expect_bc("fair_e3", 5'd9, 2'd1);
        check_eq("fair_full_e3", 64'(bus.req_full), 64'b001);
        step(0, 0, 0);
        expect_bc("fair_e4", 5'd11, 2'd0);
        check_eq("fair_full_e4", 64'(bus.req_full), 64'b000);
        step(5'd13, 0, 0);
        expect_bc("fair_e5", 5'd12, 2'd0);
        step(0, 0, 0);
        expect_bc("fair_e6", 5'd13, 2'd0);
        step(0, 0, 0);
        expect_idle("fair_e7");

        // Backpressure on the LSB queue.
        do_flush();
        step(5'd20, 5'd21, 0);
        expect_idle("bp_e1");
        step(5'd22, 5'd23, 0);
        expect_bc("bp_e2", 5'd20, 2'd0);
        check_eq("bp_full_e2", 64'(bus.req_full), 64'b010);
        step(0, 0, 0);
        expect_bc("bp_e3", 5'd21, 2'd1);
        check_eq("bp_full_e3", 64'(bus.req_full), 64'b000);
        step(0, 0, 0);
        expect_bc("bp_e4", 5'd22, 2'd0);
        step(0, 0, 0);
        expect_bc("bp_e5", 5'd23, 2'd1);
        step(0, 0, 0);
        expect_idle("bp_e6");

        // Flush with stale entries everywhere and a request in the flush cycle.
        do_flush();
        step(5'd14, 5'd15, 5'd16);
        expect_idle("fl_e1");
        step(5'd17, 5'd18, 5'd19);
        expect_bc("fl_e2", 5'd14, 2'd0);
        check_eq("fl_full_e2", 64'(bus.req_full), 64'b110);
        step(5'd24, 0, 0);
        expect_bc("fl_e3", 5'd15, 2'd1);
        check_eq("fl_full_e3", 64'(bus.req_full), 64'b101);
        flush = 1'b1;
        set_req(CDB_LSB, 5'd25, res_of(5'd25));
        tick();
        clear_req();
        flush = 1'b0;
        expect_idle("fl_after");
        check_eq("fl_full_after", 64'(bus.req_full), 64'b000);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0);
            expect_idle($sformatf("fl_quiet%0d", i));
        end
        step(0, 0, 5'd26);
        expect_idle("fl_fresh_e1");
        step(0, 0, 0);
        expect_bc("fl_fresh_e2", 5'd26, 2'd2);
        step(0, 0, 0);
        expect_idle("fl_fresh_e3");

        // rdy stall holds outputs and queues; requests during the stall are lost.
        step(5'd7, 5'd27, 0);
        expect_idle("stall_e1");
        step(0, 0, 0);
        expect_bc("stall_pre", 5'd7, 2'd0);
        rdy = 1'b0;
        set_req(CDB_BRU, 5'd28, res_of(5'd28));
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_bc($sformatf("stall_hold%0d", i), 5'd7, 2'd0);
        end
        clear_req();
        rdy = 1'b1;
        step(0, 0, 0);
        expect_bc("stall_resume", 5'd27, 2'd1);
        step(0, 0, 0);
        expect_idle("stall_lost");
        check_eq("pre_rst_tag", 64'(bus.cdb_tag), 64'd27);

        // Asynchronous reset mid-cycle.
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_vld", 64'(bus.cdb_vld), 64'd0);
        check_eq("arst_tag", 64'(bus.cdb_tag), 64'd0);
        check_eq("arst_res", 64'(bus.cdb_res), 64'd0);
        check_eq("arst_src", 64'(bus.cdb_src), 64'd0);
        check_eq("arst_full", 64'(bus.req_full), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
